pipeline_swap_sequencer: RTL
============================

Name: pipeline_swap_sequencer

Overview:
Sequences the atomic reconfiguration of the dual DSP pipelines.
- On request, it resets the inactive pipeline and grants the control unit a load window.
- It then commits and syncs the register files, enables the new pipeline, and issues a crossfade swap on a sample boundary.
- Finally it disables the retired pipeline.
- It sits between control_unit and the pipeline/mixer control wires in dsp_engine and owns the reset, enable, commit and swap strobes.

Parameters:
reset_pulse_cycles, 4, cycles the target pipeline's reset/full_reset are held high (min 1)
timeout_cycles, 65535, max cycles spent in any single wait state before abort
timeout_width, 16, counter width; must satisfy 2^timeout_width > timeout_cycles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin reconfiguration of the inactive pipeline
abort  in  1  pulse: cancel the sequence (honoured only before the swap is issued)
load_done  in  1  pulse from control unit: all block/register writes finished
sample_boundary  in  1  pulse when the engine FSM re-enters READY
current_pipeline  in  1  active pipeline index from mixer
pipelines_swapping  in  1  mixer crossfade in progress
pipeline_resetting  in  2  per-pipeline reset-in-progress
regfiles_syncing  in  2  per-pipeline regfile sync in progress
pipeline_reset  out  2  per-pipeline reset strobe
pipeline_full_reset  out  2  per-pipeline full (delay memory) reset
pipeline_enables  out  2  per-pipeline enable
reg_writes_commit  out  2  one-cycle commit strobe
swap_pipelines  out  1  one-cycle swap request to mixer
load_grant  out  1  control unit may write the target pipeline
target  out  1  pipeline being configured
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: sequence completed
error  out  1  sticky: last sequence aborted or timed out; cleared on next accepted start

Behaviour:
- Reset values: pipeline_enables=2'b01; every other output 0; state IDLE; counters 0. Asynchronous reset takes effect mid-sequence with no cleanup: outputs jump to reset values.
- All outputs are registered. Strobes are exactly one cycle wide.
- IDLE:
  - busy=0.
  - start accepted next edge: target<=~current_pipeline, error<=0, busy<=1 → RESET.
- RESET:
  - pipeline_reset[target]=pipeline_full_reset[target]=1 and pipeline_enables[target]=0 for exactly reset_pulse_cycles cycles → RSTWAIT.
- RSTWAIT:
  - The first cycle is a blind wait.
  - Then wait for pipeline_resetting[target]==0 → LOAD, with load_grant<=1.
- LOAD:
  - On load_done: load_grant<=0, reg_writes_commit[target] pulses → SYNC.
- SYNC:
  - The first cycle is a blind wait.
  - Then wait for regfiles_syncing[target]==0 → pipeline_enables[target]<=1 → ARM.
- ARM:
  - On sample_boundary: swap_pipelines pulses → SWAP.
- SWAP:
  - Wait for pipelines_swapping to be seen high, then low, with current_pipeline==target.
  - Then pipeline_enables[~target]<=0, done pulses, busy<=0 → IDLE.
- Timeout:
  - Counter cleared on every state entry; increments in RSTWAIT, LOAD, SYNC, ARM, SWAP.
  - Reaching timeout_cycles in RSTWAIT/LOAD/SYNC/ARM → ABORT.
  - Reaching it in SWAP → error<=1, then complete as the normal exit (enable retirement skipped) → IDLE.
- ABORT (one cycle):
  - pipeline_reset[target] pulses; pipeline_enables[target]<=0; load_grant<=0; error<=1; busy<=0 → IDLE.
  - The active pipeline is untouched.
- abort input: honoured in RESET..ARM. Ignored in SWAP, IDLE.
- Precedence:
  - abort beats load_done and sample_boundary in the same cycle.
  - Timeout beats load_done.
  - start while busy is ignored (no queueing).
- load_done outside LOAD is ignored. sample_boundary outside ARM is ignored.

Test Plan:
1. Happy path, current_pipeline=0:
   - start → target=1, pipeline_reset=2'b10 for 4 cycles.
   - load_grant rises after resetting[1] falls.
   - load_done → reg_writes_commit=2'b10 for 1 cycle.
   - Sync completes → enables=2'b11.
   - Boundary → swap 1 cycle; mixer sets current=1.
   - enables=2'b10, done=1.
2. Boundary gating: in ARM, hold sample_boundary low 100 cycles → swap_pipelines stays 0; pulse boundary → swap next cycle.
3. Timeout: timeout_cycles=16, never assert load_done → ABORT at 16 cycles in LOAD; error=1, enables=2'b01, pipeline_reset=2'b10 pulse.
4. Abort/load_done collision in LOAD → abort path taken, no commit strobe, error=1.
5. start while busy (in SYNC) → target unchanged, no restart; the subsequent start after done is accepted with target=0, error cleared.
6. Assert reset during ARM → all outputs immediately reset values (enables=2'b01, busy=0), no swap issued.

Source files
------------

// File: rtl/pipeline_swap_sequencer.sv
// Sequences reconfiguration of the inactive DSP pipeline: reset, load window, commit,
// regfile sync, enable, crossfade swap on a sample boundary, then retirement of the old pipeline.
module pipeline_swap_sequencer #(
  parameter int RESET_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES     = 65535,
  parameter int TIMEOUT_WIDTH      = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_load_done,
  input  logic       i_sample_boundary,
  input  logic       i_current_pipeline,
  input  logic       i_pipelines_swapping,
  input  logic [1:0] i_pipeline_resetting,
  input  logic [1:0] i_regfiles_syncing,
  output logic [1:0] o_pipeline_reset,
  output logic [1:0] o_pipeline_full_reset,
  output logic [1:0] o_pipeline_enables,
  output logic [1:0] o_reg_writes_commit,
  output logic       o_swap_pipelines,
  output logic       o_load_grant,
  output logic       o_target,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RSTWAIT = 3'd2,
    S_LOAD    = 3'd3,
    S_SYNC    = 3'd4,
    S_ARM     = 3'd5,
    S_SWAP    = 3'd6,
    S_ABORT   = 3'd7
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] RST_LAST = TIMEOUT_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ZERO = {TIMEOUT_WIDTH{1'b0}};

  state_t                   r_state, w_state_next;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_seen_swap, w_seen_swap_next;
  logic [1:0]               r_pipeline_reset, w_pipeline_reset_next;
  logic [1:0]               r_full_reset, w_full_reset_next;
  logic [1:0]               r_enables, w_enables_next;
  logic [1:0]               r_commit, w_commit_next;
  logic                     r_swap, w_swap_next;
  logic                     r_grant, w_grant_next;
  logic                     r_target, w_target_next;
  logic                     r_busy, w_busy_next;
  logic                     r_done, w_done_next;
  logic                     r_error, w_error_next;

  logic       w_timeout, w_blind, w_in_wait, w_abort_req;
  logic [1:0] w_tgt_mask, w_new_mask;

  assign w_timeout   = (r_cnt == TO_LAST);
  assign w_blind     = (r_cnt == CNT_ZERO);
  assign w_in_wait   = (r_state == S_RSTWAIT) || (r_state == S_LOAD) ||
                       (r_state == S_SYNC) || (r_state == S_ARM);
  // Abort and wait-state timeout both take priority over any forward progress.
  assign w_abort_req = ((w_in_wait || (r_state == S_RESET)) && i_abort) ||
                       (w_in_wait && w_timeout);
  assign w_tgt_mask  = r_target ? 2'b10 : 2'b01;
  assign w_new_mask  = i_current_pipeline ? 2'b01 : 2'b10;

  // Next-state and next-output logic
  always_comb begin
    w_state_next          = r_state;
    w_seen_swap_next      = r_seen_swap;
    w_pipeline_reset_next = 2'b00;
    w_full_reset_next     = 2'b00;
    w_commit_next         = 2'b00;
    w_swap_next           = 1'b0;
    w_done_next           = 1'b0;
    w_enables_next        = r_enables;
    w_grant_next          = r_grant;
    w_target_next         = r_target;
    w_busy_next           = r_busy;
    w_error_next          = r_error;
    if (w_abort_req) begin
      w_state_next          = S_ABORT;
      w_pipeline_reset_next = w_tgt_mask;
      w_enables_next        = r_enables & ~w_tgt_mask;
      w_grant_next          = 1'b0;
      w_error_next          = 1'b1;
      w_busy_next           = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_next          = S_RESET;
            w_target_next         = ~i_current_pipeline;
            w_error_next          = 1'b0;
            w_busy_next           = 1'b1;
            w_pipeline_reset_next = w_new_mask;
            w_full_reset_next     = w_new_mask;
            w_enables_next        = r_enables & ~w_new_mask;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_RESET: begin
          if (r_cnt == RST_LAST) begin
            w_state_next = S_RSTWAIT;
          end else begin
            w_pipeline_reset_next = w_tgt_mask;
            w_full_reset_next     = w_tgt_mask;
          end
        end
        S_RSTWAIT: begin
          if (!w_blind && ((i_pipeline_resetting & w_tgt_mask) == 2'b00)) begin
            w_state_next = S_LOAD;
            w_grant_next = 1'b1;
          end else begin
            w_state_next = S_RSTWAIT;
          end
        end
        S_LOAD: begin
          if (i_load_done) begin
            w_state_next  = S_SYNC;
            w_grant_next  = 1'b0;
            w_commit_next = w_tgt_mask;
          end else begin
            w_state_next = S_LOAD;
          end
        end
        S_SYNC: begin
          if (!w_blind && ((i_regfiles_syncing & w_tgt_mask) == 2'b00)) begin
            w_state_next   = S_ARM;
            w_enables_next = r_enables | w_tgt_mask;
          end else begin
            w_state_next = S_SYNC;
          end
        end
        S_ARM: begin
          if (i_sample_boundary) begin
            w_state_next     = S_SWAP;
            w_swap_next      = 1'b1;
            w_seen_swap_next = 1'b0;
          end else begin
            w_state_next = S_ARM;
          end
        end
        S_SWAP: begin
          // Completion needs the crossfade to have started and finished on the new pipeline.
          if (r_seen_swap && !i_pipelines_swapping && (i_current_pipeline == r_target)) begin
            w_state_next   = S_IDLE;
            w_enables_next = r_enables & w_tgt_mask;
            w_done_next    = 1'b1;
            w_busy_next    = 1'b0;
          end else if (w_timeout) begin
            w_state_next = S_IDLE;
            w_error_next = 1'b1;
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
          end else if (i_pipelines_swapping) begin
            w_seen_swap_next = 1'b1;
          end else begin
            w_state_next = S_SWAP;
          end
        end
        S_ABORT: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= CNT_ZERO;
      r_seen_swap      <= 1'b0;
      r_pipeline_reset <= 2'b00;
      r_full_reset     <= 2'b00;
      r_enables        <= 2'b01;
      r_commit         <= 2'b00;
      r_swap           <= 1'b0;
      r_grant          <= 1'b0;
      r_target         <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_cnt            <= (w_state_next != r_state) ? CNT_ZERO : (r_cnt + 1'b1);
      r_seen_swap      <= w_seen_swap_next;
      r_pipeline_reset <= w_pipeline_reset_next;
      r_full_reset     <= w_full_reset_next;
      r_enables        <= w_enables_next;
      r_commit         <= w_commit_next;
      r_swap           <= w_swap_next;
      r_grant          <= w_grant_next;
      r_target         <= w_target_next;
      r_busy           <= w_busy_next;
      r_done           <= w_done_next;
      r_error          <= w_error_next;
    end
  end

  assign o_pipeline_reset      = r_pipeline_reset;
  assign o_pipeline_full_reset = r_full_reset;
  assign o_pipeline_enables    = r_enables;
  assign o_reg_writes_commit   = r_commit;
  assign o_swap_pipelines      = r_swap;
  assign o_load_grant          = r_grant;
  assign o_target              = r_target;
  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_error               = r_error;

endmodule
